// File: rtl/cram_port_arbiter_pkg.sv
// Shared types and constants for the two-port cRAM arbiter.
package cram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Byte-address split: bank number above, byte offset within the bank below.
  localparam int BANK_MSB = 10;
  localparam int BANK_LSB = 8;

  // Word accesses must have these address bits clear.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // RAM write-enable encoding.
  localparam logic WEN_READ  = 1'b0;
  localparam logic WEN_WRITE = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/cram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port preferred on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic rr_ptr_q, rr_ptr_d;

  // Grant the lone requester, or the preferred port when both ask.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    gnt_o    = req_i;
    rr_ptr_d = rr_ptr_q;
    if (req_i == 2'b11) begin
      gnt_o = rr_ptr_q ? 2'b10 : 2'b01;
    end
    // After a grant, prefer the port that was not just served.
    if (advance_i) begin
      rr_ptr_d = gnt_o[0];
    end
  end

  // Pointer register; port 0 is preferred out of reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/cram_port_arbiter.sv
// Shares the 8-bank cRAM between two word-request ports: IDLE -> ACCESS -> RESP,
// with misaligned requests short-circuited straight to an error response.
module cram_port_arbiter
  import cram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [2:0]        ram_cSel,
  output logic [7:0]        ram_memA,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wEN,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  state_e state_q, state_d;

  // Latched request; the RAM drive registers double as the latched address/data.
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [2:0]        csel_q, csel_d;
  logic [7:0]        mema_q, mema_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              wen_q, wen_d;

  logic [1:0]        arb_req, arb_gnt;
  logic              accept;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              resp;
  logic [DATA_W-1:0] resp_data;

  // Requests are only arbitrated while idle, so gnt can never fire mid-transaction.
  assign arb_req = (state_q == ST_IDLE) ? {p1_req, p0_req} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req_i     (arb_req),
    .advance_i (accept),
    .gnt_o     (arb_gnt)
  );

  assign accept    = |arb_gnt;
  assign sel_port  = arb_gnt[1];
  assign sel_we    = sel_port ? p1_we    : p0_we;
  assign sel_addr  = sel_port ? p1_addr  : p0_addr;
  assign sel_wdata = sel_port ? p1_wdata : p0_wdata;

  // Next-state logic; wEN defaults to read so it can only be high during ACCESS.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    csel_d  = csel_q;
    mema_d  = mema_q;
    din_d   = din_q;
    wen_d   = WEN_READ;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          port_d = sel_port;
          we_d   = sel_we;
          err_d  = is_misaligned(sel_addr[1:0]);
          if (is_misaligned(sel_addr[1:0])) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
            csel_d  = sel_addr[BANK_MSB:BANK_LSB];
            mema_d  = sel_addr[BANK_LSB-1:0];
            din_d   = sel_wdata;
            wen_d   = sel_we ? WEN_WRITE : WEN_READ;
          end
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, latched request and RAM drive registers; reset also kills an in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      csel_q  <= '0;
      mema_q  <= '0;
      din_q   <= '0;
      wen_q   <= WEN_READ;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      csel_q  <= csel_d;
      mema_q  <= mema_d;
      din_q   <= din_d;
      wen_q   <= wen_d;
    end
  end

  assign p0_gnt = arb_gnt[0];
  assign p1_gnt = arb_gnt[1];

  // Response: read data only on a successful read; writes and errors return zero.
  assign resp      = (state_q == ST_RESP);
  assign resp_data = (resp && !we_q && !err_q) ? ram_out : '0;

  assign p0_rvalid = resp & ~port_q;
  assign p1_rvalid = resp &  port_q;
  assign p0_err    = p0_rvalid & err_q;
  assign p1_err    = p1_rvalid & err_q;
  assign p0_rdata  = port_q ? '0 : resp_data;
  assign p1_rdata  = port_q ? resp_data : '0;

  assign ram_cSel = csel_q;
  assign ram_memA = mema_q;
  assign ram_din  = din_q;
  assign ram_wEN  = wen_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cram_port_arbiter.sv
// Self-checking bench for cram_port_arbiter: directed scenarios, then randomized
// two-port traffic against a transaction-level reference model.
module tb_cram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_v, we_v;
  logic [10:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [2:0]  ram_cSel;
  logic [7:0]  ram_memA;
  logic [31:0] ram_din, ram_out;
  logic        ram_wEN, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cram_port_arbiter #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (req_v[0]),
    .p0_we     (we_v[0]),
    .p0_addr   (addr_v[0]),
    .p0_wdata  (wdata_v[0]),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_err    (p0_err),
    .p1_req    (req_v[1]),
    .p1_we     (we_v[1]),
    .p1_addr   (addr_v[1]),
    .p1_wdata  (wdata_v[1]),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .p1_err    (p1_err),
    .ram_cSel  (ram_cSel),
    .ram_memA  (ram_memA),
    .ram_din   (ram_din),
    .ram_wEN   (ram_wEN),
    .ram_out   (ram_out),
    .busy      (busy)
  );

  // Byte-addressed 8x256 RAM with registered read data, little-endian words.
  bit   [7:0]  ram_bytes [2048];
  logic [10:0] ram_a;
  assign ram_a = {ram_cSel, ram_memA};
  initial ram_out = '0;
  always @(posedge clk) begin
    if (ram_wEN) begin
      ram_bytes[ram_a]     <= ram_din[7:0];
      ram_bytes[ram_a + 1] <= ram_din[15:8];
      ram_bytes[ram_a + 2] <= ram_din[23:16];
      ram_bytes[ram_a + 3] <= ram_din[31:24];
    end
    ram_out <= {ram_bytes[ram_a + 3], ram_bytes[ram_a + 2], ram_bytes[ram_a + 1], ram_bytes[ram_a]};
  end

  // Records every cycle the RAM sees a write strobe and what was driven.
  int          wen_count = 0;
  logic [2:0]  last_csel = '0;
  logic [7:0]  last_mema = '0;
  logic [31:0] last_din  = '0;
  always @(negedge clk) begin
    if (ram_wEN === 1'b1) begin
      wen_count++;
      last_csel = ram_cSel;
      last_mema = ram_memA;
      last_din  = ram_din;
    end
  end

  // Reference memory: one word per aligned address.
  logic [31:0] mem_model [512];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request on one port: wait for gnt (bounded), then count cycles to rvalid.
  task automatic xact(input int p, input logic we, input logic [10:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int w;
    @(negedge clk);
    req_v[p] = 1'b1; we_v[p] = we; addr_v[p] = a; wdata_v[p] = d;
    #1;
    w = 0;
    while (!(p == 0 ? p0_gnt : p1_gnt) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check("gnt_seen", w < 20, 1);
    @(negedge clk);
    req_v[p] = 1'b0;
    #1;
    lat = 1;
    while (!(p == 0 ? p0_rvalid : p1_rvalid) && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    rd = (p == 0) ? p0_rdata : p1_rdata;
    er = (p == 0) ? p0_err : p1_err;
    if (we && a[1:0] == 2'b00 && lat < 10) mem_model[a[10:2]] = d;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, n0;
    // random-phase model state
    bit          pend [2];
    int          pref, free_at, busy_from, resp_cyc, resp_port, wen_cyc, g;
    logic [31:0] resp_data;
    logic        resp_err, mis;
    logic [1:0]  eg, ev;
    logic [8:0]  ridx;
    logic [1:0]  rlo;

    for (int i = 0; i < 512; i++) mem_model[i] = '0;
    rst = 1'b1;
    req_v = '0; we_v = '0;
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wen", ram_wEN, 0);
    check("rst_csel_mema", {ram_cSel, ram_memA}, 0);
    check("rst_din", ram_din, 0);
    check("rst_flags", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
    check("rst_rdata", p0_rdata | p1_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read back on port 0
    n0 = wen_count;
    xact(0, 1'b1, 11'h304, 32'hDEADBEEF, rd, er, lat);
    check("wr_latency", lat, 2);
    check("wr_err", er, 0);
    check("wr_rdata_zero", rd, 0);
    check("wr_wen_cycles", wen_count - n0, 1);
    check("wr_csel", last_csel, 3);
    check("wr_mema", last_mema, 8'h04);
    check("wr_din", last_din, 32'hDEADBEEF);
    xact(0, 1'b0, 11'h304, 32'h0, rd, er, lat);
    check("rd_latency", lat, 2);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", er, 0);

    // Both ports reading continuously from reset: p0, p1, p0, p1 every 3 cycles
    do_reset();
    n0 = wen_count;
    @(negedge clk);
    req_v = 2'b11; we_v = 2'b00;
    addr_v[0] = 11'h304; addr_v[1] = 11'h304;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("rr_p0_gnt", p0_gnt, (c % 6) == 0);
      check("rr_p1_gnt", p1_gnt, (c % 6) == 3);
      check("rr_p0_rvalid", p0_rvalid, (c % 6) == 2);
      check("rr_p1_rvalid", p1_rvalid, (c % 6) == 5);
      check("rr_p0_rdata", p0_rdata, ((c % 6) == 2) ? 32'hDEADBEEF : 32'h0);
      check("rr_p1_rdata", p1_rdata, ((c % 6) == 5) ? 32'hDEADBEEF : 32'h0);
      @(negedge clk);
    end
    req_v = 2'b00;
    check("rr_no_writes", wen_count - n0, 0);

    // Misaligned write on port 1 never reaches the RAM
    xact(1, 1'b1, 11'h100, 32'hCAFEF00D, rd, er, lat);
    n0 = wen_count;
    xact(1, 1'b1, 11'h102, 32'h12345678, rd, er, lat);
    check("mis_latency", lat, 1);
    check("mis_err", er, 1);
    check("mis_rdata", rd, 0);
    check("mis_no_wen", wen_count - n0, 0);
    xact(1, 1'b0, 11'h100, 32'h0, rd, er, lat);
    check("mis_prior_data", rd, 32'hCAFEF00D);
    check("mis_prior_err", er, 0);

    // Bank/offset boundaries
    xact(0, 1'b1, 11'h0FC, 32'hA5A5A5A5, rd, er, lat);
    check("bnd_csel0", last_csel, 0);
    check("bnd_mema252", last_mema, 8'd252);
    xact(1, 1'b1, 11'h700, 32'h5A5A5A5A, rd, er, lat);
    check("bnd_csel7", last_csel, 7);
    check("bnd_mema0", last_mema, 8'd0);
    xact(0, 1'b0, 11'h0FC, 32'h0, rd, er, lat);
    check("bnd_rd_0fc", rd, 32'hA5A5A5A5);
    xact(1, 1'b0, 11'h700, 32'h0, rd, er, lat);
    check("bnd_rd_700", rd, 32'h5A5A5A5A);

    // Reset in the middle of a write's ACCESS cycle
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 11'h010; wdata_v[0] = 32'h11111111;
    #1;
    check("rm_gnt", p0_gnt, 1);
    @(negedge clk);
    req_v[0] = 1'b0;
    #1;
    check("rm_access_wen", ram_wEN, 1);
    rst = 1'b1;
    #1;
    check("rm_wen_killed", ram_wEN, 0);
    check("rm_busy_cleared", busy, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("rm_no_rvalid", {p1_rvalid, p0_rvalid}, 0);
    end
    rst = 1'b0;
    req_v = 2'b11; we_v = 2'b00; addr_v[0] = 11'h010; addr_v[1] = 11'h010;
    #1;
    check("rm_p0_first", {p1_gnt, p0_gnt}, 2'b01);
    @(negedge clk);
    req_v = 2'b00;
    @(negedge clk); #1;
    check("rm_rd_rvalid", {p1_rvalid, p0_rvalid}, 2'b01);
    check("rm_rd_unwritten", p0_rdata, 0);

    // Idle hygiene
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      check("idle_quiet", {ram_wEN, busy, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 0);
    end

    // Randomized traffic on both ports against a transaction-level model
    do_reset();
    pend[0] = 0; pend[1] = 0;
    pref = 0; free_at = 0; busy_from = 0;
    resp_cyc = -1; resp_port = 0; wen_cyc = -1;
    resp_data = '0; resp_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]    = 1;
          ridx       = 9'($urandom_range(0, 511));
          rlo        = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          addr_v[p]  = {ridx, rlo};
          we_v[p]    = 1'($urandom_range(0, 1));
          wdata_v[p] = $urandom;
        end
        req_v[p] = pend[p];
      end
      #1;
      eg = 2'b00;
      if (cyc >= free_at) begin
        if (pend[0] && pend[1]) eg = (pref == 1) ? 2'b10 : 2'b01;
        else if (pend[0])       eg = 2'b01;
        else if (pend[1])       eg = 2'b10;
      end
      ev = (cyc == resp_cyc) ? ((resp_port == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("rand_gnt", {p1_gnt, p0_gnt}, eg);
      check("rand_rvalid", {p1_rvalid, p0_rvalid}, ev);
      check("rand_p0_rdata", p0_rdata, ev[0] ? resp_data : 32'h0);
      check("rand_p1_rdata", p1_rdata, ev[1] ? resp_data : 32'h0);
      check("rand_err", {p1_err, p0_err}, {ev[1] & resp_err, ev[0] & resp_err});
      check("rand_wen", ram_wEN, cyc == wen_cyc);
      check("rand_busy", busy, (cyc >= busy_from) && (cyc < free_at));
      if (eg != 2'b00) begin
        g         = eg[1] ? 1 : 0;
        mis       = (addr_v[g][1:0] != 2'b00);
        pref      = 1 - g;
        resp_port = g;
        resp_cyc  = cyc + (mis ? 1 : 2);
        busy_from = cyc + 1;
        free_at   = resp_cyc + 1;
        wen_cyc   = (!mis && we_v[g]) ? cyc + 1 : -1;
        resp_err  = mis;
        resp_data = (mis || we_v[g]) ? 32'h0 : mem_model[addr_v[g][10:2]];
        if (!mis && we_v[g]) mem_model[addr_v[g][10:2]] = wdata_v[g];
        pend[g]   = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
